// File: rtl/apb_gpio_ext_pkg.sv
// Shared definitions for the APB GPIO controller: register word offsets and interrupt types.
// Pure definitions, no logic or latency.
package apb_gpio_ext_pkg;

    localparam logic [3:0] REG_DIR       = 4'h0;
    localparam logic [3:0] REG_IN        = 4'h1;
    localparam logic [3:0] REG_OUT       = 4'h2;
    localparam logic [3:0] REG_OUTSET    = 4'h3;
    localparam logic [3:0] REG_OUTCLR    = 4'h4;
    localparam logic [3:0] REG_INTEN     = 4'h5;
    localparam logic [3:0] REG_INTTYPE0  = 4'h6;
    localparam logic [3:0] REG_INTTYPE1  = 4'h7;
    localparam logic [3:0] REG_INTSTATUS = 4'h8;
    localparam logic [3:0] REG_FILTEN    = 4'h9;
    localparam logic [3:0] REG_FILTCNT   = 4'hA;
    localparam logic [3:0] REG_FUN0      = 4'hB;
    localparam logic [3:0] REG_FUN1      = 4'hC;

    // Encoding is {INTTYPE1, INTTYPE0}; bit 1 set means edge-triggered.
    typedef enum logic [1:0] {
        LEV_HI = 2'b00,
        LEV_LO = 2'b01,
        RISE   = 2'b10,
        FALL   = 2'b11
    } int_type_e;

endpackage

// File: rtl/gpio_in_filter.sv
// Single-pin input path: 2-flop synchroniser, counter glitch filter, edge detector.
// Latency 2 cycles to r_in (+filt_cnt when filtering); no backpressure.
module gpio_in_filter #(
    parameter int FILT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_in,
    input  logic              filt_en,
    input  logic [FILT_W-1:0] filt_cnt,
    output logic              r_in,
    output logic              rise,
    output logic              fall
);

    logic              sync0_q, sync0_d;
    logic              sync1_q, sync1_d;
    logic              r_in_q, r_in_d;
    logic              r_prev_q, r_prev_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync0_d  = pad_in;
        sync1_d  = sync0_q;
        r_prev_d = r_in_q;
        r_in_d   = r_in_q;
        cnt_d    = '0;
        if (!filt_en) begin
            r_in_d = sync1_q;
        end else if (sync1_q != r_in_q) begin
            // >= guards against a threshold lowered below an in-flight count
            if (cnt_q >= filt_cnt) begin
                r_in_d = sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            r_in_q   <= 1'b0;
            r_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync0_q  <= sync0_d;
            sync1_q  <= sync1_d;
            r_in_q   <= r_in_d;
            r_prev_q <= r_prev_d;
            cnt_q    <= cnt_d;
        end
    end

    assign r_in = r_in_q;
    assign rise = r_in_q & ~r_prev_q;
    assign fall = ~r_in_q & r_prev_q;

endmodule

// File: rtl/apb_gpio_ext.sv
// APB GPIO controller with atomic set/clear, sticky interrupt status and per-pin glitch filter.
// Zero-wait-state APB (PREADY tied 1); interrupt lags pad input by 3 cycles unfiltered.
module apb_gpio_ext
    import apb_gpio_ext_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_GPIO        = 32,
    parameter int FILT_W         = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NB_GPIO-1:0]        gpio_in,
    output logic [NB_GPIO-1:0]        gpio_out,
    output logic [NB_GPIO-1:0]        gpio_dir,
    output logic [2*NB_GPIO-1:0]      gpio_mux,
    output logic                      interrupt
);

    logic [3:0]         reg_idx;
    logic               apb_acc, apb_err, wr_ok, rd_clr;
    logic [NB_GPIO-1:0] wdata_pin;
    logic [NB_GPIO-1:0] r_in, rise, fall, evt, edge_evt;

    logic [NB_GPIO-1:0] dir_q, dir_d, out_q, out_d, inten_q, inten_d;
    logic [NB_GPIO-1:0] type0_q, type0_d, type1_q, type1_d, status_q, status_d;
    logic [NB_GPIO-1:0] filten_q, filten_d, fun0_q, fun0_d, fun1_q, fun1_d;
    logic [FILT_W-1:0]  filtcnt_q, filtcnt_d;

    logic unused_apb_bits;
    assign unused_apb_bits = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0], PWDATA};

    assign reg_idx   = PADDR[5:2];
    assign wdata_pin = PWDATA[NB_GPIO-1:0];
    assign apb_acc   = PSEL & PENABLE;
    assign apb_err   = apb_acc & ((reg_idx > REG_FUN1) |
                       (PWRITE & ((reg_idx == REG_IN) | (reg_idx == REG_INTSTATUS))));
    assign wr_ok     = apb_acc & PWRITE & ~apb_err;
    assign rd_clr    = apb_acc & ~PWRITE & (reg_idx == REG_INTSTATUS);

    for (genvar g = 0; g < NB_GPIO; g++) begin : g_pin
        gpio_in_filter #(.FILT_W(FILT_W)) u_filt (
            .clk      (HCLK),
            .rst_n    (HRESETn),
            .pad_in   (gpio_in[g]),
            .filt_en  (filten_q[g]),
            .filt_cnt (filtcnt_q),
            .r_in     (r_in[g]),
            .rise     (rise[g]),
            .fall     (fall[g])
        );
    end

    always_comb begin
        evt = '0;
        for (int i = 0; i < NB_GPIO; i++) begin
            unique case (int_type_e'({type1_q[i], type0_q[i]}))
                LEV_HI: evt[i] = r_in[i];
                LEV_LO: evt[i] = ~r_in[i];
                RISE:   evt[i] = rise[i];
                FALL:   evt[i] = fall[i];
            endcase
        end
        evt      = evt & inten_q;
        edge_evt = evt & type1_q;
    end

    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        inten_d   = inten_q;
        type0_d   = type0_q;
        type1_d   = type1_q;
        filten_d  = filten_q;
        filtcnt_d = filtcnt_q;
        fun0_d    = fun0_q;
        fun1_d    = fun1_q;
        // A clearing read keeps only edge events coincident with it; level
        // conditions re-assert on the following cycle instead.
        status_d  = rd_clr ? edge_evt : (status_q | evt);
        if (wr_ok) begin
            case (reg_idx)
                REG_DIR:      dir_d     = wdata_pin;
                REG_OUT:      out_d     = wdata_pin;
                REG_OUTSET:   out_d     = out_q | wdata_pin;
                REG_OUTCLR:   out_d     = out_q & ~wdata_pin;
                REG_INTEN:    inten_d   = wdata_pin;
                REG_INTTYPE0: type0_d   = wdata_pin;
                REG_INTTYPE1: type1_d   = wdata_pin;
                REG_FILTEN:   filten_d  = wdata_pin;
                REG_FILTCNT:  filtcnt_d = PWDATA[FILT_W-1:0];
                REG_FUN0:     fun0_d    = wdata_pin;
                REG_FUN1:     fun1_d    = wdata_pin;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dir_q     <= '0;
            out_q     <= '0;
            inten_q   <= '0;
            type0_q   <= '0;
            type1_q   <= '0;
            status_q  <= '0;
            filten_q  <= '0;
            filtcnt_q <= '0;
            fun0_q    <= '0;
            fun1_q    <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            inten_q   <= inten_d;
            type0_q   <= type0_d;
            type1_q   <= type1_d;
            status_q  <= status_d;
            filten_q  <= filten_d;
            filtcnt_q <= filtcnt_d;
            fun0_q    <= fun0_d;
            fun1_q    <= fun1_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        case (reg_idx)
            REG_DIR:       PRDATA = 32'(dir_q);
            REG_IN:        PRDATA = 32'(r_in);
            REG_OUT:       PRDATA = 32'(out_q);
            REG_INTEN:     PRDATA = 32'(inten_q);
            REG_INTTYPE0:  PRDATA = 32'(type0_q);
            REG_INTTYPE1:  PRDATA = 32'(type1_q);
            REG_INTSTATUS: PRDATA = 32'(status_q);
            REG_FILTEN:    PRDATA = 32'(filten_q);
            REG_FILTCNT:   PRDATA = 32'(filtcnt_q);
            REG_FUN0:      PRDATA = 32'(fun0_q);
            REG_FUN1:      PRDATA = 32'(fun1_q);
            default:       PRDATA = '0;
        endcase
    end

    assign PREADY    = 1'b1;
    assign PSLVERR   = apb_err;
    assign gpio_out  = out_q;
    assign gpio_dir  = dir_q;
    assign gpio_mux  = {fun1_q, fun0_q};
    assign interrupt = |status_q;

endmodule

// File: tb/tb_apb_gpio_ext.sv
// Directed bench for apb_gpio_ext with 8 pads: register map, set/clear, filter and interrupts.
module tb_apb_gpio_ext;

    localparam int NB = 8;

    logic          HCLK, HRESETn;
    logic [11:0]   PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [NB-1:0] gpio_in, gpio_out, gpio_dir;
    logic [2*NB-1:0] gpio_mux;
    logic          interrupt;

    int checks   = 0;
    int failures = 0;

    apb_gpio_ext #(.APB_ADDR_WIDTH(12), .NB_GPIO(NB), .FILT_W(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_dir(gpio_dir), .gpio_mux(gpio_mux), .interrupt(interrupt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        #1;
        d   = PRDATA;
        err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0;
        PENABLE = 1'b0; gpio_in = '0;
        repeat (3) tick();
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", interrupt); end
        checks++; if (gpio_out !== '0) begin failures++; $display("FAIL rst_out got=%h exp=0", gpio_out); end
        checks++; if (gpio_dir !== '0) begin failures++; $display("FAIL rst_dir got=%h exp=0", gpio_dir); end
        checks++; if (gpio_mux !== '0) begin failures++; $display("FAIL rst_mux got=%h exp=0", gpio_mux); end
        checks++; if (PSLVERR !== 1'b0) begin failures++; $display("FAIL rst_slverr got=%b exp=0", PSLVERR); end
        HRESETn = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) begin
            apb_rd(12'(a * 4), d, e);
            checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_read off=%0h got=%h exp=0", a * 4, d); end
            checks++; if (e !== (a >= 13)) begin failures++; $display("FAIL rst_rd_err off=%0h got=%b exp=%b", a * 4, e, a >= 13); end
        end
        apb_wr(12'h034, 32'hFFFF_FFFF, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL wr_unmapped_err got=%b exp=1", e); end
        apb_wr(12'h004, 32'hFFFF_FFFF, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL wr_in_err got=%b exp=1", e); end
        apb_wr(12'h020, 32'hFFFF_FFFF, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL wr_status_err got=%b exp=1", e); end
        for (int a = 0; a < 13; a++) begin
            apb_rd(12'(a * 4), d, e);
            checks++; if (d !== 32'h0) begin failures++; $display("FAIL err_noeffect off=%0h got=%h exp=0", a * 4, d); end
        end
        checks++; if (gpio_out !== '0) begin failures++; $display("FAIL err_out got=%h exp=0", gpio_out); end
    endtask

    task automatic test_out_setclr();
        logic [31:0] d;
        logic        e;
        apb_wr(12'h000, 32'h0000_00FF, e);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL dir_err got=%b exp=0", e); end
        checks++; if (gpio_dir !== 8'hFF) begin failures++; $display("FAIL dir got=%h exp=ff", gpio_dir); end
        apb_wr(12'h008, 32'h0000_00F0, e);
        apb_wr(12'h00C, 32'h0000_0003, e);
        apb_wr(12'h010, 32'h0000_0010, e);
        checks++; if (gpio_out !== 8'hE3) begin failures++; $display("FAIL setclr_out got=%h exp=e3", gpio_out); end
        apb_rd(12'h008, d, e);
        checks++; if (d !== 32'hE3) begin failures++; $display("FAIL setclr_rd got=%h exp=e3", d); end
        apb_rd(12'h00C, d, e);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL outset_rd got=%h exp=0", d); end
        apb_rd(12'h010, d, e);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL outclr_rd got=%h exp=0", d); end
        apb_wr(12'h008, 32'hFFFF_FFFF, e);
        apb_rd(12'h008, d, e);
        checks++; if (d !== 32'hFF) begin failures++; $display("FAIL out_mask got=%h exp=ff", d); end
        apb_wr(12'h02C, 32'h0000_000F, e);
        apb_wr(12'h030, 32'h0000_00A5, e);
        checks++; if (gpio_mux !== 16'hA50F) begin failures++; $display("FAIL mux got=%h exp=a50f", gpio_mux); end
    endtask

    task automatic test_rise_irq();
        logic [31:0] d;
        logic        e;
        apb_wr(12'h01C, 32'h1, e);
        apb_wr(12'h014, 32'h1, e);
        PADDR = 12'h004;
        gpio_in[0] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++; if (PRDATA !== {31'b0, j >= 2}) begin failures++; $display("FAIL rise_in j=%0d got=%h exp=%0d", j, PRDATA, j >= 2); end
            checks++; if (interrupt !== (j >= 3)) begin failures++; $display("FAIL rise_irq j=%0d got=%b exp=%0d", j, interrupt, j >= 3); end
        end
        gpio_in[0] = 1'b0;
        repeat (4) tick();
        apb_rd(12'h020, d, e);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL rise_status got=%h exp=1", d); end
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL rise_clr_irq got=%b exp=0", interrupt); end
    endtask

    task automatic test_filter();
        logic [31:0] d;
        logic        e;
        logic        seen_in, seen_irq;
        apb_wr(12'h024, 32'h1, e);
        apb_wr(12'h028, 32'h3, e);
        apb_rd(12'h028, d, e);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL filtcnt_rd got=%h exp=3", d); end
        PADDR = 12'h004;
        seen_in = 1'b0; seen_irq = 1'b0;
        gpio_in[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (j == 2) gpio_in[0] = 1'b0;
            seen_in  = seen_in | PRDATA[0];
            seen_irq = seen_irq | interrupt;
        end
        checks++; if (seen_in !== 1'b0) begin failures++; $display("FAIL filt_short_in got=%b exp=0", seen_in); end
        checks++; if (seen_irq !== 1'b0) begin failures++; $display("FAIL filt_short_irq got=%b exp=0", seen_irq); end
        gpio_in[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (j == 3) gpio_in[0] = 1'b0;
            checks++; if (PRDATA[0] !== (j >= 5 && j <= 8)) begin failures++; $display("FAIL filt_long_in j=%0d got=%b exp=%0d", j, PRDATA[0], j >= 5 && j <= 8); end
            checks++; if (interrupt !== (j >= 6)) begin failures++; $display("FAIL filt_long_irq j=%0d got=%b exp=%0d", j, interrupt, j >= 6); end
        end
        apb_rd(12'h020, d, e);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL filt_status got=%h exp=1", d); end
        apb_wr(12'h024, 32'h0, e);
    endtask

    task automatic test_level_and_clear();
        logic [31:0] d;
        logic        e;
        gpio_in[5] = 1'b1;
        repeat (4) tick();
        apb_wr(12'h018, 32'h24, e);
        apb_wr(12'h01C, 32'h21, e);
        apb_wr(12'h014, 32'h25, e);
        apb_rd(12'h020, d, e);
        checks++; if (d !== 32'h4) begin failures++; $display("FAIL levlo_rd got=%h exp=4", d); end
        checks++; if (PRDATA !== 32'h0) begin failures++; $display("FAIL levlo_cleared got=%h exp=0", PRDATA); end
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL levlo_clr_irq got=%b exp=0", interrupt); end
        tick();
        checks++; if (PRDATA !== 32'h4) begin failures++; $display("FAIL levlo_reset got=%h exp=4", PRDATA); end
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL levlo_irq got=%b exp=1", interrupt); end
        gpio_in[5] = 1'b0;
        tick();
        tick();
        apb_rd(12'h020, d, e);
        checks++; if (d !== 32'h4) begin failures++; $display("FAIL fall_rd got=%h exp=4", d); end
        checks++; if (PRDATA !== 32'h20) begin failures++; $display("FAIL fall_kept got=%h exp=20", PRDATA); end
        tick();
        checks++; if (PRDATA !== 32'h24) begin failures++; $display("FAIL fall_plus_lev got=%h exp=24", PRDATA); end
        apb_wr(12'h014, 32'h0, e);
        PADDR = 12'h020;
        #1;
        checks++; if (PRDATA !== 32'h24) begin failures++; $display("FAIL inten_clr_keeps got=%h exp=24", PRDATA); end
    endtask

    task automatic test_reset_mid();
        logic e;
        gpio_in[3] = 1'b1;
        repeat (4) tick();
        PADDR = 12'h004;
        #1;
        checks++; if (PRDATA !== 32'h8) begin failures++; $display("FAIL pre_rst_in got=%h exp=8", PRDATA); end
        apb_wr(12'h024, 32'h1, e);
        apb_wr(12'h028, 32'h3, e);
        PADDR = 12'h004;
        gpio_in[0] = 1'b1;
        repeat (3) tick();
        checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL pre_rst_irq got=%b exp=1", interrupt); end
        HRESETn = 1'b0;
        #1;
        checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%b exp=0", interrupt); end
        checks++; if (PRDATA !== 32'h0) begin failures++; $display("FAIL mid_rst_in got=%h exp=0", PRDATA); end
        checks++; if (gpio_dir !== '0) begin failures++; $display("FAIL mid_rst_dir got=%h exp=0", gpio_dir); end
        checks++; if (gpio_out !== '0) begin failures++; $display("FAIL mid_rst_out got=%h exp=0", gpio_out); end
        gpio_in[0] = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
        repeat (4) tick();
        PADDR = 12'h020;
        #1;
        checks++; if (PRDATA !== 32'h0) begin failures++; $display("FAIL post_rst_status got=%h exp=0", PRDATA); end
        apb_wr(12'h024, 32'h1, e);
        apb_wr(12'h028, 32'h3, e);
        PADDR = 12'h004;
        gpio_in[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (j == 3) gpio_in[0] = 1'b0;
            checks++; if (PRDATA[0] !== (j >= 5 && j <= 8)) begin failures++; $display("FAIL post_rst_filt j=%0d got=%b exp=%0d", j, PRDATA[0], j >= 5 && j <= 8); end
        end
    endtask

    initial begin
        test_reset();
        test_out_setclr();
        test_rise_irq();
        test_filter();
        test_level_and_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
